// File: rtl/vec_mem_if.sv
// Processor-control and data-memory bus of the vector memory unit.
interface vec_mem_if #(
    parameter int unsigned LANES = 8,
    parameter int unsigned EW    = 8,
    parameter int unsigned AW    = 16
);
    // processor control side
    logic                  cl_mem_st;
    logic [1:0]            cl_mem_op;
    logic [AW-1:0]         base_addr;
    logic [LANES*EW-1:0]   vec_wdata;
    logic [EW-1:0]         esc_wdata;
    logic                  mem_rdy;
    logic [LANES*EW-1:0]   vec_rdata;
    logic [EW-1:0]         esc_rdata;
    // data memory side
    logic [AW-1:0]         dmem_addr;
    logic                  dmem_we;
    logic [EW-1:0]         dmem_wdata;
    logic                  dmem_re;
    logic [EW-1:0]         dmem_rdata;

    // The memory unit itself.
    modport slave (
        input  cl_mem_st, cl_mem_op, base_addr, vec_wdata, esc_wdata, dmem_rdata,
        output mem_rdy, vec_rdata, esc_rdata, dmem_addr, dmem_we, dmem_wdata, dmem_re
    );

    // Processor control plus data memory surrounding the unit.
    modport master (
        output cl_mem_st, cl_mem_op, base_addr, vec_wdata, esc_wdata, dmem_rdata,
        input  mem_rdy, vec_rdata, esc_rdata, dmem_addr, dmem_we, dmem_wdata, dmem_re
    );
endinterface

// File: rtl/vec_mem_unit.sv
// Vector/scalar load-store unit: sequences one data-memory access per element.
// op[1]=1 load, op[1]=0 store; op[0]=1 scalar (1 element), op[0]=0 vector (LANES).
module vec_mem_unit #(
    parameter int unsigned LANES = 8,
    parameter int unsigned EW    = 8,
    parameter int unsigned AW    = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    vec_mem_if.slave  vm
);

    localparam int unsigned VW = LANES * EW;
    localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST_V = IW'(LANES - 1);

    typedef enum logic [2:0] {IDLE, STORE, LOAD, LWAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] base_q, base_d;
    logic [VW-1:0] vwd_q, vwd_d;
    logic [EW-1:0] ewd_q, ewd_d;
    logic          cap_q, cap_d;
    logic [IW-1:0] cap_idx_q, cap_idx_d;
    logic          rdy_q, rdy_d;
    logic          we_q, we_d;
    logic          re_q, re_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [EW-1:0] wdata_q, wdata_d;
    logic [VW-1:0] vrd_q, vrd_d;
    logic [EW-1:0] erd_q, erd_d;
    logic          issue;
    logic [IW-1:0] last_idx;

    // Next-state, operand latching, read-data capture and registered strobe decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        base_d    = base_q;
        vwd_d     = vwd_q;
        ewd_d     = ewd_q;
        cap_d     = 1'b0;
        cap_idx_d = idx_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        vrd_d     = vrd_q;
        erd_d     = erd_q;
        issue     = 1'b0;
        last_idx  = op_q[0] ? '0 : LAST_V;

        // Read data arrives the cycle after its strobe; file it under that strobe's index.
        if (cap_q) begin
            if (op_q[0]) begin
                erd_d = vm.dmem_rdata;
            end else begin
                vrd_d[cap_idx_q*EW +: EW] = vm.dmem_rdata;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (vm.cl_mem_st) begin
                    op_d    = vm.cl_mem_op;
                    base_d  = vm.base_addr;
                    vwd_d   = vm.vec_wdata;
                    ewd_d   = vm.esc_wdata;
                    idx_d   = '0;
                    state_d = vm.cl_mem_op[1] ? LOAD : STORE;
                    issue   = 1'b1;
                end
            end
            STORE, LOAD: begin
                cap_d     = (state_q == LOAD);
                cap_idx_d = idx_q;
                if (idx_q == last_idx) begin
                    state_d = (state_q == LOAD) ? LWAIT : DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                    issue = 1'b1;
                end
            end
            LWAIT: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes for the element handled in the next cycle.
        if (issue) begin
            addr_d = base_d + AW'(idx_d);
            if (state_d == STORE) begin
                we_d    = 1'b1;
                wdata_d = op_d[0] ? ewd_d : vwd_d[idx_d*EW +: EW];
            end else begin
                re_d = 1'b1;
            end
        end

        rdy_d = (state_d == IDLE) || (state_d == DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            op_q      <= '0;
            base_q    <= '0;
            vwd_q     <= '0;
            ewd_q     <= '0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
            rdy_q     <= 1'b1;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            vrd_q     <= '0;
            erd_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            op_q      <= op_d;
            base_q    <= base_d;
            vwd_q     <= vwd_d;
            ewd_q     <= ewd_d;
            cap_q     <= cap_d;
            cap_idx_q <= cap_idx_d;
            rdy_q     <= rdy_d;
            we_q      <= we_d;
            re_q      <= re_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            vrd_q     <= vrd_d;
            erd_q     <= erd_d;
        end
    end

    assign vm.mem_rdy    = rdy_q;
    assign vm.dmem_we    = we_q;
    assign vm.dmem_re    = re_q;
    assign vm.dmem_addr  = addr_q;
    assign vm.dmem_wdata = wdata_q;
    assign vm.vec_rdata  = vrd_q;
    assign vm.esc_rdata  = erd_q;

endmodule

// File: tb/tb_vec_mem_unit.sv
// Self-checking bench for vec_mem_unit with a data-memory model and access logs.
module tb_vec_mem_unit;

    localparam int unsigned LANES = 8;
    localparam int unsigned EW    = 8;
    localparam int unsigned AW    = 16;
    localparam int unsigned VW    = LANES * EW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    vec_mem_if #(.LANES(LANES), .EW(EW), .AW(AW)) vif ();

    vec_mem_unit #(.LANES(LANES), .EW(EW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vm    (vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [EW-1:0] data;
    } acc_t;

    acc_t          wlog[$];
    acc_t          rlog[$];
    logic [EW-1:0] mem [0:(1<<AW)-1];
    int            cyc      = 0;
    int            both_cnt = 0;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [VW-1:0] exp_vec  = '0;
    logic [EW-1:0] exp_esc  = '0;

    // Data memory model: writes land at the edge, reads return one cycle after the strobe.
    always @(posedge clk) begin
        if (rst_n) begin
            if (vif.dmem_we && vif.dmem_re) both_cnt = both_cnt + 1;
            if (vif.dmem_re) rlog.push_back('{cyc, vif.dmem_addr, mem[vif.dmem_addr]});
            vif.dmem_rdata <= vif.dmem_re ? mem[vif.dmem_addr] : EW'($urandom);
            if (vif.dmem_we) begin
                wlog.push_back('{cyc, vif.dmem_addr, vif.dmem_wdata});
                mem[vif.dmem_addr] = vif.dmem_wdata;
            end
        end
        cyc = cyc + 1;
    end

    // Drive a one-cycle start from a negedge; operand inputs are scrambled afterwards.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] base,
                         input logic [VW-1:0] vw, input logic [EW-1:0] ew);
        vif.cl_mem_op = op;
        vif.base_addr = base;
        vif.vec_wdata = vw;
        vif.esc_wdata = ew;
        vif.cl_mem_st = 1'b1;
        @(negedge clk);
        vif.cl_mem_st = 1'b0;
        vif.cl_mem_op = 2'($urandom);
        vif.base_addr = AW'($urandom);
        for (int i = 0; i < LANES; i++) vif.vec_wdata[i*EW +: EW] = EW'($urandom);
        vif.esc_wdata = EW'($urandom);
    endtask

    // Count cycles (first cycle after acceptance = 1) until mem_rdy is seen high.
    task automatic wait_rdy(output int lat);
        lat = 1;
        while (vif.mem_rdy !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        vif.cl_mem_st = 1'b0; vif.cl_mem_op = 2'b00; vif.base_addr = '0;
        vif.vec_wdata = '0;   vif.esc_wdata = '0;    vif.dmem_rdata = '0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (vif.mem_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", vif.mem_rdy); end
        n_checks++; if (vif.dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", vif.dmem_we); end
        n_checks++; if (vif.dmem_re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b want 0", vif.dmem_re); end
        n_checks++; if (vif.dmem_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", vif.dmem_addr); end
        n_checks++; if (vif.dmem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", vif.dmem_wdata); end
        n_checks++; if (vif.vec_rdata !== '0) begin n_fail++; $display("FAIL reset_vec: got %h want 0", vif.vec_rdata); end
        n_checks++; if (vif.esc_rdata !== '0) begin n_fail++; $display("FAIL reset_esc: got %h want 0", vif.esc_rdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at the release negedge: the start must be taken on the first edge after reset.
    task automatic test_store_vector;
        int lat;
        logic [VW-1:0] vw;
        for (int i = 0; i < LANES; i++) vw[i*EW +: EW] = EW'(8'h11 * (i + 1));
        wlog.delete(); rlog.delete();
        issue(2'b00, 16'h0010, vw, 8'h00);
        wait_rdy(lat);
        n_checks++; if (lat != LANES + 1) begin n_fail++; $display("FAIL stv_latency: got %0d want %0d", lat, LANES + 1); end
        n_checks++; if (wlog.size() != LANES) begin n_fail++; $display("FAIL stv_count: got %0d want %0d", wlog.size(), LANES); end
        for (int i = 0; i < LANES && i < wlog.size(); i++) begin
            n_checks++;
            if (wlog[i].addr !== AW'(16'h0010 + i) || wlog[i].data !== EW'(8'h11 * (i + 1)) || wlog[i].cyc != wlog[0].cyc + i) begin
                n_fail++;
                $display("FAIL stv_write%0d: got addr %h data %h cyc+%0d want addr %h data %h cyc+%0d", i,
                         wlog[i].addr, wlog[i].data, wlog[i].cyc - wlog[0].cyc, AW'(16'h0010 + i), EW'(8'h11 * (i + 1)), i);
            end
        end
        n_checks++; if (vif.vec_rdata !== exp_vec || vif.esc_rdata !== exp_esc) begin n_fail++; $display("FAIL stv_rdata_hold: got %h/%h want %h/%h", vif.vec_rdata, vif.esc_rdata, exp_vec, exp_esc); end
    endtask

    task automatic test_load_vector;
        int lat;
        logic [VW-1:0] want;
        for (int i = 0; i < LANES; i++) want[i*EW +: EW] = EW'(8'h11 * (i + 1));
        wlog.delete(); rlog.delete();
        @(negedge clk);
        issue(2'b10, 16'h0010, '1, 8'hFF);
        wait_rdy(lat);
        n_checks++; if (lat != LANES + 2) begin n_fail++; $display("FAIL ldv_latency: got %0d want %0d", lat, LANES + 2); end
        n_checks++; if (vif.vec_rdata !== want) begin n_fail++; $display("FAIL ldv_vec: got %h want %h", vif.vec_rdata, want); end
        n_checks++; if (vif.esc_rdata !== exp_esc) begin n_fail++; $display("FAIL ldv_esc_hold: got %h want %h", vif.esc_rdata, exp_esc); end
        n_checks++; if (rlog.size() != LANES || wlog.size() != 0) begin n_fail++; $display("FAIL ldv_strobes: got %0d reads %0d writes want %0d reads 0 writes", rlog.size(), wlog.size(), LANES); end
        exp_vec = want;
    endtask

    task automatic test_back_to_back;
        int lat, lat2;
        wlog.delete(); rlog.delete();
        @(negedge clk);
        issue(2'b01, 16'h0003, '0, 8'h5A);
        wait_rdy(lat);
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sts_latency: got %0d want 2", lat); end
        issue(2'b11, 16'h0003, '0, 8'h00);
        n_checks++; if (vif.mem_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", vif.mem_rdy); end
        wait_rdy(lat2);
        n_checks++; if (lat2 != 3) begin n_fail++; $display("FAIL lds_latency: got %0d want 3", lat2); end
        n_checks++; if (vif.esc_rdata !== 8'h5A) begin n_fail++; $display("FAIL lds_esc: got %h want 5a", vif.esc_rdata); end
        n_checks++; if (vif.vec_rdata !== exp_vec) begin n_fail++; $display("FAIL lds_vec_hold: got %h want %h", vif.vec_rdata, exp_vec); end
        n_checks++;
        if (wlog.size() != 1 || rlog.size() != 1) begin
            n_fail++; $display("FAIL b2b_strobes: got %0d writes %0d reads want 1 and 1", wlog.size(), rlog.size());
        end else if (wlog[0].addr !== 16'h0003 || rlog[0].addr !== 16'h0003 || rlog[0].cyc != wlog[0].cyc + 2) begin
            n_fail++; $display("FAIL b2b_timing: got waddr %h raddr %h gap %0d want 0003 0003 2", wlog[0].addr, rlog[0].addr, rlog[0].cyc - wlog[0].cyc);
        end
        exp_esc = 8'h5A;
    endtask

    task automatic test_wrap;
        int lat;
        logic [VW-1:0] want;
        for (int i = 0; i < LANES; i++) begin
            want[i*EW +: EW] = EW'($urandom);
            mem[AW'(16'hFFFE + i)] = want[i*EW +: EW];
        end
        wlog.delete(); rlog.delete();
        @(negedge clk);
        issue(2'b10, 16'hFFFE, '0, '0);
        wait_rdy(lat);
        n_checks++; if (lat != LANES + 2) begin n_fail++; $display("FAIL wrap_latency: got %0d want %0d", lat, LANES + 2); end
        n_checks++; if (rlog.size() != LANES) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", rlog.size(), LANES); end
        for (int i = 0; i < LANES && i < rlog.size(); i++) begin
            n_checks++;
            if (rlog[i].addr !== AW'(16'hFFFE + i)) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", i, rlog[i].addr, AW'(16'hFFFE + i)); end
        end
        n_checks++; if (vif.vec_rdata !== want) begin n_fail++; $display("FAIL wrap_vec: got %h want %h", vif.vec_rdata, want); end
        exp_vec = want;
    endtask

    task automatic test_ignore_start;
        int lat;
        logic [VW-1:0] vw;
        logic [AW-1:0] base;
        for (int i = 0; i < LANES; i++) vw[i*EW +: EW] = EW'($urandom);
        base = AW'($urandom);
        wlog.delete(); rlog.delete();
        @(negedge clk);
        issue(2'b00, base, vw, '0);
        @(negedge clk);
        @(negedge clk);
        vif.cl_mem_op = 2'b10;
        vif.cl_mem_st = 1'b1;
        @(negedge clk);
        vif.cl_mem_st = 1'b0;
        wait_rdy(lat);
        n_checks++; if (lat + 3 != LANES + 1) begin n_fail++; $display("FAIL ign_latency: got %0d want %0d", lat + 3, LANES + 1); end
        n_checks++; if (wlog.size() != LANES) begin n_fail++; $display("FAIL ign_count: got %0d want %0d", wlog.size(), LANES); end
        for (int i = 0; i < LANES && i < wlog.size(); i++) begin
            n_checks++;
            if (wlog[i].addr !== AW'(base + i) || wlog[i].data !== vw[i*EW +: EW]) begin
                n_fail++; $display("FAIL ign_write%0d: got %h/%h want %h/%h", i, wlog[i].addr, wlog[i].data, AW'(base + i), vw[i*EW +: EW]);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++; if (rlog.size() != 0 || wlog.size() != LANES || vif.mem_rdy !== 1'b1) begin n_fail++; $display("FAIL ign_after: got %0d reads %0d writes rdy %b want 0 %0d 1", rlog.size(), wlog.size(), vif.mem_rdy, LANES); end
    endtask

    task automatic test_reset_abort;
        int lat, k;
        logic [VW-1:0] vw;
        for (int i = 0; i < LANES; i++) vw[i*EW +: EW] = EW'($urandom);
        wlog.delete(); rlog.delete();
        @(negedge clk);
        issue(2'b00, 16'h0100, vw, '0);
        k = 0;
        while (wlog.size() < 4 && k < 20) begin @(negedge clk); k++; end
        n_checks++; if (wlog.size() != 4) begin n_fail++; $display("FAIL abort_pre: got %0d writes want 4", wlog.size()); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (vif.dmem_we !== 1'b0 || vif.dmem_re !== 1'b0 || vif.mem_rdy !== 1'b1 || vif.dmem_addr !== '0 ||
            vif.dmem_wdata !== '0 || vif.vec_rdata !== '0 || vif.esc_rdata !== '0) begin
            n_fail++;
            $display("FAIL abort_async: got we %b re %b rdy %b addr %h wd %h vec %h esc %h want 0 0 1 0 0 0 0",
                     vif.dmem_we, vif.dmem_re, vif.mem_rdy, vif.dmem_addr, vif.dmem_wdata, vif.vec_rdata, vif.esc_rdata);
        end
        exp_vec = '0;
        exp_esc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (wlog.size() != 4 || rlog.size() != 0) begin n_fail++; $display("FAIL abort_quiet: got %0d writes %0d reads want 4 0", wlog.size(), rlog.size()); end
        issue(2'b01, 16'h0200, '0, 8'hC3);
        wait_rdy(lat);
        n_checks++;
        if (lat != 2 || wlog.size() != 5 || wlog[wlog.size()-1].addr !== 16'h0200 || wlog[wlog.size()-1].data !== 8'hC3) begin
            n_fail++; $display("FAIL abort_restart: got lat %0d writes %0d last %h/%h want 2 5 0200/c3",
                               lat, wlog.size(), wlog[wlog.size()-1].addr, wlog[wlog.size()-1].data);
        end
    endtask

    // Random ops, randomly back-to-back, against a per-operation reference model.
    task automatic test_random;
        int lat, n, exp_lat;
        logic [1:0]    op;
        logic [AW-1:0] base;
        logic [VW-1:0] vw;
        logic [EW-1:0] ew;
        logic [AW-1:0] ea [LANES];
        logic [EW-1:0] ed [LANES];
        @(negedge clk);
        for (int t = 0; t < 24; t++) begin
            op   = 2'($urandom);
            base = (t % 4 == 0) ? AW'(16'hFFFF - $urandom_range(0, 3)) : AW'($urandom);
            for (int i = 0; i < LANES; i++) vw[i*EW +: EW] = EW'($urandom);
            ew   = EW'($urandom);
            n    = op[0] ? 1 : LANES;
            exp_lat = op[1] ? n + 2 : n + 1;
            for (int i = 0; i < n; i++) begin
                ea[i] = AW'(base + i);
                if (op[1]) begin
                    ed[i] = EW'($urandom);
                    mem[ea[i]] = ed[i];
                end else begin
                    ed[i] = op[0] ? ew : vw[i*EW +: EW];
                end
            end
            if (op == 2'b10) for (int i = 0; i < LANES; i++) exp_vec[i*EW +: EW] = ed[i];
            if (op == 2'b11) exp_esc = ed[0];
            wlog.delete(); rlog.delete();
            issue(op, base, vw, ew);
            wait_rdy(lat);
            n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency: op %b got %0d want %0d", t, op, lat, exp_lat); end
            n_checks++;
            if ((op[1] ? rlog.size() : wlog.size()) != n || (op[1] ? wlog.size() : rlog.size()) != 0) begin
                n_fail++; $display("FAIL rnd%0d_count: op %b got %0d writes %0d reads want %0d", t, op, wlog.size(), rlog.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    n_checks++;
                    if (op[1] ? (rlog[i].addr !== ea[i]) : (wlog[i].addr !== ea[i] || wlog[i].data !== ed[i])) begin
                        n_fail++; $display("FAIL rnd%0d_elem%0d: op %b got %h/%h want %h/%h", t, i, op,
                                           op[1] ? rlog[i].addr : wlog[i].addr, op[1] ? rlog[i].data : wlog[i].data, ea[i], ed[i]);
                    end
                end
            end
            n_checks++; if (vif.vec_rdata !== exp_vec) begin n_fail++; $display("FAIL rnd%0d_vec: op %b got %h want %h", t, op, vif.vec_rdata, exp_vec); end
            n_checks++; if (vif.esc_rdata !== exp_esc) begin n_fail++; $display("FAIL rnd%0d_esc: op %b got %h want %h", t, op, vif.esc_rdata, exp_esc); end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_store_vector();
        test_load_vector();
        test_back_to_back();
        test_wrap();
        test_ignore_start();
        test_reset_abort();
        test_random();
        repeat (2) @(negedge clk);
        n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles with we and re want 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vec_mem_unit.md
VEC_MEM_UNIT -- requirements
Module: vec_mem_unit

Interface
REQ-001 Parameter LANES, default 8, number of vector elements.
REQ-002 Parameter EW, default 8, element and scalar width in bits.
REQ-003 Parameter AW, default 16, data-memory address width.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cl_mem_st  in  1  start request from processor control.
REQ-007 cl_mem_op  in  2  10 load vector, 11 load scalar, 00 store vector, 01 store scalar.
REQ-008 base_addr  in  AW  element-0 address.
REQ-009 vec_wdata  in  LANES*EW  store-vector source; lane i = bits [i*EW +: EW].
REQ-010 esc_wdata  in  EW  store-scalar source.
REQ-011 mem_rdy  out  1  high when idle or on completion; low while an operation is in progress.
REQ-012 vec_rdata  out  LANES*EW  load-vector result.
REQ-013 esc_rdata  out  EW  load-scalar result.
REQ-014 dmem_addr  out  AW  data-memory address.
REQ-015 dmem_we  out  1  data-memory write strobe.
REQ-016 dmem_wdata  out  EW  data-memory write data.
REQ-017 dmem_re  out  1  data-memory read strobe.
REQ-018 dmem_rdata  in  EW  read data; valid exactly one cycle after dmem_re.

Function
REQ-019 FSM states: IDLE, STORE, LOAD, LWAIT, DONE.
REQ-020 A start is accepted on a rising edge where cl_mem_st=1 and the state is IDLE or DONE.
- On acceptance, latch cl_mem_op, base_addr, vec_wdata and esc_wdata.
- Clear the element counter idx to 0.
- Enter STORE for ops 0x, LOAD for ops 1x.
REQ-021 cl_mem_st in STORE, LOAD or LWAIT is ignored; no queuing.
REQ-022 mem_rdy=1 in IDLE and DONE, 0 in STORE, LOAD and LWAIT (registered state decode).
REQ-023 STORE, one cycle per element:
- dmem_we=1, dmem_addr=base+idx, dmem_wdata=latched lane idx (vector) or latched esc_wdata (scalar).
- Element count is LANES for vector, 1 for scalar.
- After the last element, enter DONE.
REQ-024 LOAD, one cycle per element:
- dmem_re=1, dmem_addr=base+idx.
- After the last read, enter LWAIT.
REQ-025 In every cycle following a read strobe (LOAD or LWAIT), capture dmem_rdata into the lane of the previous idx (vector) or into esc_rdata (scalar).
REQ-026 LWAIT lasts one cycle (final capture), then enter DONE.
REQ-027 DONE lasts one cycle with all results final, then IDLE unless a new start is accepted.
REQ-028 Latency from the accepting edge to the first DONE cycle:
- Store vector: LANES+1 cycles. Store scalar: 2 cycles.
- Load vector: LANES+2 cycles. Load scalar: 3 cycles.
REQ-029 Address arithmetic is modulo 2^AW; base+idx wraps past all-ones to 0.
REQ-030 dmem_we and dmem_re are never both 1, and both are 0 outside STORE/LOAD.
REQ-031 Outside STORE/LOAD, dmem_addr and dmem_wdata hold their last value.
REQ-032 vec_rdata and esc_rdata change only by REQ-025 captures and hold otherwise.
- A store leaves both unchanged.
- A scalar load leaves vec_rdata unchanged.
REQ-033 A back-to-back start accepted in DONE begins the new operation the next cycle with no IDLE bubble.

Reset
REQ-034 rst_n=0 immediately forces all state and outputs, independent of clk:
- state IDLE, idx 0, mem_rdy 1.
- dmem_we 0, dmem_re 0, dmem_addr 0, dmem_wdata 0.
- vec_rdata 0, esc_rdata 0, all latched operands 0.
REQ-035 Reset asserted mid-operation aborts it; no further dmem strobes occur until a new start is accepted after release.
REQ-036 The first start can be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-037 Store vector, base 0x0010, lanes 0..7 = 0x11..0x88 -> writes to 0x0010..0x0017 on 8 consecutive cycles; mem_rdy low 8 cycles, high on the 9th.
REQ-038 Load vector from 0x0010 (memory model returns 0x11..0x88) -> vec_rdata lane i = 0x11*(i+1); DONE on cycle 10; esc_rdata unchanged.
REQ-039 Store scalar 0x5A to 0x0003, then load scalar from 0x0003 started in the DONE cycle -> esc_rdata=0x5A; no idle cycle between the two operations.
REQ-040 Load vector at base 0xFFFE -> read addresses 0xFFFE, 0xFFFF, 0x0000..0x0005.
REQ-041 cl_mem_st pulsed in cycle 3 of a vector store -> ignored; exactly 8 writes occur.
REQ-042 rst_n asserted after the 4th write of a vector store -> all outputs at reset values asynchronously; no write occurs after release until a new start.
